// File: rtl/tx_packet_builder.sv
// Transmit-side framer: arbitrates round-robin between N_CH response channels and
// serialises one packet at a time as PREFIX, HOST_ADDR, channel, LEN, payload, checksum.
module tx_packet_builder #(
   parameter int         N_CH      = 5,
   parameter logic [7:0] PREFIX    = 8'hDD,
   parameter logic [7:0] HOST_ADDR = 8'h01
) (
   input  logic              fpga_clk_48,
   input  logic              reset,
   input  logic [N_CH-1:0]   req_bus,
   input  logic [N_CH*8-1:0] len_bus,
   input  logic [N_CH*8-1:0] data_bus,
   input  logic [N_CH-1:0]   valid_bus,
   output logic [N_CH-1:0]   ready_bus,
   output logic [N_CH-1:0]   grant_bus,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy
);

   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_PREFIX, S_SRC, S_DST, S_LEN, S_PAYLOAD, S_CSUM
   } state_t;

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  rr_q, rr_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        csum_q, csum_d;
   logic [N_CH-1:0]   grant_q, grant_d;

   logic              hit;
   int                scan_idx;
   logic [SEL_W-1:0]  pick;
   logic [7:0]        pick_len;
   logic [N_CH-1:0]   pick_onehot;
   logic [7:0]        pay_byte;
   logic              pay_valid;
   logic              pay_xfer;

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      hit         = 1'b0;
      scan_idx    = 0;
      pick        = rr_q;
      pick_len    = '0;
      pick_onehot = '0;
      for (int k = 1; k <= N_CH; k++) begin
         scan_idx = (int'(rr_q) + k) % N_CH;
         if (!hit && req_bus[scan_idx]) begin
            hit                   = 1'b1;
            pick                  = SEL_W'(scan_idx);
            pick_len              = len_bus[8*scan_idx +: 8];
            pick_onehot[scan_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      pay_byte  = '0;
      pay_valid = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_q == SEL_W'(i)) begin
            pay_byte  = data_bus[8*i +: 8];
            pay_valid = valid_bus[i];
         end
      end
   end

   assign pay_xfer = (state_q == S_PAYLOAD) && pay_valid && tx_ready;

   always_ff @(posedge fpga_clk_48 or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         rr_q    <= SEL_W'(N_CH - 1);
         len_q   <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rr_q    <= rr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      csum_d  = csum_q;
      grant_d = grant_q;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               state_d = S_PREFIX;
               sel_d   = pick;
               rr_d    = pick;
               len_d   = pick_len;
               grant_d = pick_onehot;
               cnt_d   = '0;
               csum_d  = '0;
            end
         end
         S_PREFIX: if (tx_ready) state_d = S_SRC;
         S_SRC:    if (tx_ready) state_d = S_DST;
         S_DST:    if (tx_ready) state_d = S_LEN;
         S_LEN:    if (tx_ready) state_d = (len_q == 8'd0) ? S_CSUM : S_PAYLOAD;
         S_PAYLOAD: begin
            if (pay_xfer) begin
               csum_d = csum_q + pay_byte;
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == len_q - 8'd1) state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (tx_ready) begin
               state_d = S_IDLE;
               grant_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Header bytes come from registers; payload is a straight pass-through of the granted channel.
   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      ready_bus = '0;
      case (state_q)
         S_PREFIX: begin tx_valid = 1'b1; tx_data = PREFIX;    end
         S_SRC:    begin tx_valid = 1'b1; tx_data = HOST_ADDR; end
         S_DST:    begin tx_valid = 1'b1; tx_data = 8'(sel_q); end
         S_LEN:    begin tx_valid = 1'b1; tx_data = len_q;     end
         S_PAYLOAD: begin
            tx_valid  = pay_valid;
            tx_data   = pay_byte;
            ready_bus = grant_q & {N_CH{tx_ready}};
         end
         S_CSUM:   begin tx_valid = 1'b1; tx_data = csum_q;    end
         default: ;
      endcase
   end

   assign grant_bus = grant_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_packet_builder.sv
// Directed bench for tx_packet_builder: frames are checked byte by byte against
// hand-written expected streams, with handshake and arbitration checks along the way.
module tb_tx_packet_builder;

   localparam int N_CH = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [N_CH-1:0]   req_bus;
   logic [N_CH*8-1:0] len_bus;
   logic [N_CH*8-1:0] data_bus;
   logic [N_CH-1:0]   valid_bus;
   logic [N_CH-1:0]   ready_bus;
   logic [N_CH-1:0]   grant_bus;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;

   int errors = 0;
   int checks = 0;

   tx_packet_builder #(.N_CH(N_CH), .PREFIX(8'hDD), .HOST_ADDR(8'h01)) dut (
      .fpga_clk_48 (clk),
      .reset       (reset),
      .req_bus     (req_bus),
      .len_bus     (len_bus),
      .data_bus    (data_bus),
      .valid_bus   (valid_bus),
      .ready_bus   (ready_bus),
      .grant_bus   (grant_bus),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one channel's packet and checks every transferred byte, ready_bus and holds.
   task automatic run_frame(input int ch, input logic [7:0] len, input logic [7:0] pay [$],
                            input logic [7:0] csum, input bit toggle, input int stall_at,
                            input int abort_at, input string tag);
      logic [7:0]      exp [$];
      logic [N_CH-1:0] exp_ready;
      logic [7:0]      held;
      bit              hold, granted, done;
      int              idx, pi, stall_cnt, cyc;
      exp = {8'hDD, 8'h01, 8'(ch), len};
      for (int i = 0; i < int'(len); i++) exp.push_back(pay[i]);
      exp.push_back(csum);
      hold = 0; granted = 0; done = 0;
      idx = 0; pi = 0; stall_cnt = 0; cyc = 0;
      len_bus[8*ch +: 8] = len;
      req_bus[ch] = 1'b1;
      while (!done && cyc < 1000) begin
         @(negedge clk);
         tx_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
         if (pi < int'(len)) data_bus[8*ch +: 8] = pay[pi];
         if (idx == stall_at && stall_cnt < 4 && (stall_cnt > 0 || !hold)) begin
            valid_bus[ch] = 1'b0;
            stall_cnt++;
         end else begin
            valid_bus[ch] = (pi < int'(len));
         end
         #1;
         if (!granted && grant_bus != '0) begin
            chk({tag, " grant"}, 32'(grant_bus), 32'(1) << ch);
            granted = 1;
            req_bus[ch] = 1'b0;
         end
         if (granted && idx == abort_at) begin
            chk({tag, " valid_before_reset"}, 32'(tx_valid), 32'd1);
            reset = 1'b1;
            #1;
            chk({tag, " reset_tx_valid"}, 32'(tx_valid), 32'd0);
            chk({tag, " reset_grant"}, 32'(grant_bus), 32'd0);
            chk({tag, " reset_busy"}, 32'(busy), 32'd0);
            reset = 1'b0;
            done = 1;
         end else begin
            exp_ready = '0;
            if (idx >= 4 && idx < 4 + int'(len)) exp_ready[ch] = tx_ready;
            chk({tag, " ready_bus"}, 32'(ready_bus), 32'(exp_ready));
            if (hold) chk({tag, " hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
            hold = tx_valid && !tx_ready;
            held = tx_data;
            if (tx_valid && tx_ready) begin
               chk($sformatf("%s byte%0d", tag, idx), 32'(tx_data), 32'(exp[idx]));
               if (idx >= 4 && idx < 4 + int'(len)) pi++;
               idx++;
               if (idx == exp.size()) done = 1;
            end
         end
         cyc++;
      end
      chk({tag, " completed"}, 32'(done), 32'd1);
      if (abort_at < 0) begin
         @(negedge clk);
         #1;
         chk({tag, " idle_busy"}, 32'(busy), 32'd0);
         chk({tag, " idle_grant"}, 32'(grant_bus), 32'd0);
         chk({tag, " idle_valid"}, 32'(tx_valid), 32'd0);
      end
   endtask

   initial begin
      logic [7:0] pay [$];
      reset = 1'b1;
      req_bus = '0; len_bus = '0; data_bus = '0; valid_bus = '0; tx_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst tx_valid", 32'(tx_valid), 32'd0);
      chk("rst tx_data", 32'(tx_data), 32'd0);
      chk("rst grant", 32'(grant_bus), 32'd0);
      chk("rst ready", 32'(ready_bus), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      reset = 1'b0;

      pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      run_frame(2, 8'd6, pay, 8'h15, 0, -1, -1, "ch2_len6");

      pay = {};
      run_frame(0, 8'd0, pay, 8'h00, 0, -1, -1, "ch0_len0");

      for (int rep = 0; rep < 2; rep++) begin
         len_bus[8*3 +: 8] = 8'd1;
         data_bus[8*3 +: 8] = 8'hBB;
         valid_bus[3] = 1'b1;
         req_bus[3] = 1'b1;
         pay = {8'hAA};
         run_frame(1, 8'd1, pay, 8'hAA, 0, -1, -1, "rr_ch1");
         pay = {8'hBB};
         run_frame(3, 8'd1, pay, 8'hBB, 0, -1, -1, "rr_ch3");
      end

      pay = {8'hFF, 8'hFF, 8'h03};
      run_frame(4, 8'd3, pay, 8'h01, 1, 5, -1, "ch4_stall");

      pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      run_frame(2, 8'd6, pay, 8'h00, 0, -1, 6, "ch2_abort");

      len_bus[8*4 +: 8] = 8'd1;
      req_bus[4] = 1'b1;
      pay = {8'h10, 8'h20};
      run_frame(0, 8'd2, pay, 8'h30, 0, -1, -1, "post_rst_ch0");
      pay = {8'h7E};
      run_frame(4, 8'd1, pay, 8'h7E, 0, -1, -1, "post_rst_ch4");

      pay = {};
      for (int i = 0; i < 255; i++) pay.push_back(8'h01);
      run_frame(2, 8'd255, pay, 8'hFF, 0, -1, -1, "ch2_len255");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
